// File: rtl/hyperram_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : hyperram_cmd_sched
//  Description : Command scheduler for the HyperRAM register-read,
//                memory-read and memory-write sequencers. Arbitrates user
//                requests, builds the 48-bit CA word, pulses the selected
//                sequencer's start, muxes the shared pad from the current
//                owner, enforces CS# high time between transactions and
//                aborts a hung sequencer with a watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module hyperram_cmd_sched #(
    parameter int CSHI_CYC     = 2,
    parameter int TIMEOUT_CYC  = 64,
    parameter bit BURST_LINEAR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdreg_req,
    input  logic        rdmem_req,
    input  logic        wrmem_req,
    input  logic [31:0] rdreg_addr,
    input  logic [31:0] rdmem_addr,
    input  logic [31:0] wrmem_addr,
    output logic        rdreg_ack,
    output logic        rdmem_ack,
    output logic        wrmem_ack,
    output logic [47:0] casig,
    output logic [2:0]  sub_start,
    input  logic [2:0]  sub_end,
    input  logic [2:0]  sub_oe,
    input  logic [2:0]  sub_oe_clk,
    input  logic [2:0]  sub_csn,
    input  logic [47:0] sub_datain,
    input  logic        wr_rwds_out,
    input  logic        wr_rwds_oe,
    output logic        pad_oe,
    output logic        pad_oe_clk,
    output logic        pad_csn,
    output logic [15:0] pad_datain,
    output logic        pad_rwds_out,
    output logic        pad_rwds_oe,
    output logic        sub_rst,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clr
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT_END = 3'd2,
        S_ABORT    = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_RDREG = 2'd1,
        OWN_RDMEM = 2'd2,
        OWN_WRMEM = 2'd3
    } owner_t;

    // The watchdog counts the incremented value, so WAIT_END lasts
    // TIMEOUT_CYC-1 cycles and ABORT lands TIMEOUT_CYC cycles after START.
    localparam logic [7:0] WD_LAST  = 8'(TIMEOUT_CYC - 1);
    localparam logic [3:0] GAP_LAST = 4'(CSHI_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    owner_t      owner;
    owner_t      grant;
    logic        rr_ptr;
    logic [7:0]  wd;
    logic [7:0]  wd_inc;
    logic [3:0]  gap;
    logic [2:0]  owner_onehot;
    logic        owner_req;
    logic        owner_end;
    logic [31:0] addr_sel;
    logic [47:0] ca_word;

    // Arbitration: rdreg first, then round-robin between the memory requesters
    always_comb begin
        grant = OWN_NONE;
        if (rdreg_req) begin
            grant = OWN_RDREG;
        end else if (rdmem_req && wrmem_req) begin
            grant = rr_ptr ? OWN_WRMEM : OWN_RDMEM;
        end else if (rdmem_req) begin
            grant = OWN_RDMEM;
        end else if (wrmem_req) begin
            grant = OWN_WRMEM;
        end
    end

    // CA word for the requester about to be granted
    always_comb begin
        addr_sel = 32'd0;
        case (grant)
            OWN_RDREG: addr_sel = rdreg_addr;
            OWN_RDMEM: addr_sel = rdmem_addr;
            OWN_WRMEM: addr_sel = wrmem_addr;
            default:   addr_sel = 32'd0;
        endcase
        ca_word = {(grant != OWN_WRMEM),
                   (grant == OWN_RDREG),
                   ((grant == OWN_RDREG) ? 1'b1 : BURST_LINEAR),
                   addr_sel[31:3],
                   13'd0,
                   addr_sel[2:0]};
    end

    // Owner decode into the {wrmem,rdmem,rdreg} bit order of the sub_* buses
    always_comb begin
        owner_onehot = 3'b000;
        case (owner)
            OWN_RDREG: owner_onehot = 3'b001;
            OWN_RDMEM: owner_onehot = 3'b010;
            OWN_WRMEM: owner_onehot = 3'b100;
            default:   owner_onehot = 3'b000;
        endcase
        owner_req = |(owner_onehot & {wrmem_req, rdmem_req, rdreg_req});
        owner_end = |(owner_onehot & sub_end);
        wd_inc    = wd + 8'd1;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-state strobes
    always_comb begin
        state_nxt = state;
        sub_start = 3'b000;
        sub_rst   = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant != OWN_NONE) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                // A requester that let go before its ack is not served
                if (owner_req) begin
                    sub_start = owner_onehot;
                    state_nxt = S_WAIT_END;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT_END: begin
                if (owner_end) begin
                    state_nxt = S_GAP;
                end else if (wd_inc == WD_LAST) begin
                    state_nxt = S_ABORT;
                end
            end
            S_ABORT: begin
                sub_rst   = 1'b1;
                state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap == GAP_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign rdreg_ack = sub_start[0];
    assign rdmem_ack = sub_start[1];
    assign wrmem_ack = sub_start[2];
    assign busy      = (state != S_IDLE);

    // Owner, CA word and round-robin pointer, all latched at grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner  <= OWN_NONE;
            casig  <= 48'd0;
            rr_ptr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    owner <= grant;
                    if (grant != OWN_NONE) begin
                        casig <= ca_word;
                    end
                    if (grant == OWN_RDMEM) begin
                        rr_ptr <= 1'b1;
                    end else if (grant == OWN_WRMEM) begin
                        rr_ptr <= 1'b0;
                    end
                end
                S_START: begin
                    if (!owner_req) begin
                        owner <= OWN_NONE;
                    end
                end
                S_WAIT_END: begin
                    if (owner_end) begin
                        owner <= OWN_NONE;
                    end
                end
                S_ABORT: owner <= OWN_NONE;
                default: owner <= OWN_NONE;
            endcase
        end
    end

    // Watchdog and CS# high-time counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd  <= 8'd0;
            gap <= 4'd0;
        end else begin
            case (state)
                S_START:    wd  <= 8'd0;
                S_WAIT_END: begin
                    wd  <= wd_inc;
                    gap <= 4'd0;
                end
                S_ABORT:    gap <= 4'd0;
                S_GAP:      gap <= gap + 4'd1;
                default: begin
                    wd  <= wd;
                    gap <= gap;
                end
            endcase
        end
    end

    // Sticky timeout flag; a pending abort beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_err <= 1'b0;
        end else if (state == S_ABORT) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

    // Pad mux driven from the registered owner; no owner means idle pad
    always_comb begin
        pad_oe       = 1'b0;
        pad_oe_clk   = 1'b0;
        pad_csn      = 1'b1;
        pad_datain   = 16'd0;
        pad_rwds_out = 1'b0;
        pad_rwds_oe  = 1'b0;
        case (owner)
            OWN_RDREG: begin
                pad_oe     = sub_oe[0];
                pad_oe_clk = sub_oe_clk[0];
                pad_csn    = sub_csn[0];
                pad_datain = sub_datain[15:0];
            end
            OWN_RDMEM: begin
                pad_oe     = sub_oe[1];
                pad_oe_clk = sub_oe_clk[1];
                pad_csn    = sub_csn[1];
                pad_datain = sub_datain[31:16];
            end
            OWN_WRMEM: begin
                pad_oe       = sub_oe[2];
                pad_oe_clk   = sub_oe_clk[2];
                pad_csn      = sub_csn[2];
                pad_datain   = sub_datain[47:32];
                pad_rwds_out = wr_rwds_out;
                pad_rwds_oe  = wr_rwds_oe;
            end
            default: begin
                pad_csn = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_hyperram_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hyperram_cmd_sched
//  Description : Directed self-checking bench for hyperram_cmd_sched.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hyperram_cmd_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdreg_req = 1'b0, rdmem_req = 1'b0, wrmem_req = 1'b0;
    logic [31:0] rdreg_addr = 32'd0, rdmem_addr = 32'd0, wrmem_addr = 32'd0;
    logic        rdreg_ack, rdmem_ack, wrmem_ack;
    logic [47:0] casig;
    logic [2:0]  sub_start;
    logic [2:0]  sub_end = 3'b000;
    logic [2:0]  sub_oe = 3'b000, sub_oe_clk = 3'b000, sub_csn = 3'b111;
    logic [47:0] sub_datain = 48'd0;
    logic        wr_rwds_out = 1'b0, wr_rwds_oe = 1'b0;
    logic        pad_oe, pad_oe_clk, pad_csn;
    logic [15:0] pad_datain;
    logic        pad_rwds_out, pad_rwds_oe;
    logic        sub_rst, busy, timeout_err;
    logic        err_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    hyperram_cmd_sched #(
        .CSHI_CYC    (2),
        .TIMEOUT_CYC (64),
        .BURST_LINEAR(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdreg_req   (rdreg_req),
        .rdmem_req   (rdmem_req),
        .wrmem_req   (wrmem_req),
        .rdreg_addr  (rdreg_addr),
        .rdmem_addr  (rdmem_addr),
        .wrmem_addr  (wrmem_addr),
        .rdreg_ack   (rdreg_ack),
        .rdmem_ack   (rdmem_ack),
        .wrmem_ack   (wrmem_ack),
        .casig       (casig),
        .sub_start   (sub_start),
        .sub_end     (sub_end),
        .sub_oe      (sub_oe),
        .sub_oe_clk  (sub_oe_clk),
        .sub_csn     (sub_csn),
        .sub_datain  (sub_datain),
        .wr_rwds_out (wr_rwds_out),
        .wr_rwds_oe  (wr_rwds_oe),
        .pad_oe      (pad_oe),
        .pad_oe_clk  (pad_oe_clk),
        .pad_csn     (pad_csn),
        .pad_datain  (pad_datain),
        .pad_rwds_out(pad_rwds_out),
        .pad_rwds_oe (pad_rwds_oe),
        .sub_rst     (sub_rst),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse reset and return everything to a quiet bus
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        rdreg_req = 1'b0; rdmem_req = 1'b0; wrmem_req = 1'b0;
        sub_end = 3'b000; sub_oe = 3'b000; sub_oe_clk = 3'b000; sub_csn = 3'b111;
        sub_datain = 48'd0; wr_rwds_out = 1'b0; wr_rwds_oe = 1'b0; err_clr = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Wait (bounded) for a start pulse at negedge; leaves time in the START cycle
    task automatic wait_start(output int n);
        n = 0;
        @(negedge clk);
        while (sub_start == 3'b000 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One complete transaction: check grant, then the sequencer finishes quickly
    task automatic run_txn(input string tag, input logic [2:0] exp_start, input logic [47:0] exp_ca);
        int n;
        wait_start(n);
        check_val({tag, "_start"}, {61'd0, sub_start}, {61'd0, exp_start});
        check_val({tag, "_ack"}, {61'd0, wrmem_ack, rdmem_ack, rdreg_ack}, {61'd0, exp_start});
        check_val({tag, "_ca"}, {16'd0, casig}, {16'd0, exp_ca});
        @(posedge clk); #1;
        sub_end = exp_start;
        @(posedge clk); #1;
        sub_end = 3'b000;
    endtask

    initial begin : main
        int n;

        // ---------------- reset values ----------------
        #2;
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_casig", {16'd0, casig}, 64'd0);
        check_val("rst_pad_csn", {63'd0, pad_csn}, 64'd1);
        check_val("rst_terr", {63'd0, timeout_err}, 64'd0);
        check_val("rst_start", {61'd0, sub_start}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // ---------------- register read ----------------
        rdreg_addr = 32'h0000_0001;
        rdreg_req  = 1'b1;
        @(negedge clk);
        check_val("rdreg_ack_early", {63'd0, rdreg_ack}, 64'd0);
        @(negedge clk);
        check_val("rdreg_ack", {63'd0, rdreg_ack}, 64'd1);
        check_val("rdreg_start", {61'd0, sub_start}, 64'd1);
        check_val("rdreg_ca", {16'd0, casig}, 64'h0000_E000_0000_0001);
        @(posedge clk); #1;
        rdreg_req = 1'b0;
        sub_csn   = 3'b110;
        @(negedge clk);
        check_val("rdreg_pad_csn", {63'd0, pad_csn}, 64'd0);
        check_val("rdreg_busy", {63'd0, busy}, 64'd1);
        // an end strobe from a sequencer that does not own the bus is ignored
        @(posedge clk); #1;
        sub_end = 3'b010;
        @(posedge clk); #1;
        sub_end = 3'b000;
        @(negedge clk);
        check_val("foreign_end", {63'd0, pad_csn}, 64'd0);
        repeat (16) @(posedge clk);
        #1;
        sub_end = 3'b001;
        @(posedge clk); #1;
        sub_end = 3'b000;
        @(negedge clk);
        check_val("gap0_csn", {63'd0, pad_csn}, 64'd1);
        check_val("gap0_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check_val("gap1_csn", {63'd0, pad_csn}, 64'd1);
        check_val("gap1_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        check_val("gap_done_busy", {63'd0, busy}, 64'd0);
        sub_csn = 3'b111;

        // ---------------- memory round-robin ----------------
        do_reset();
        rdmem_addr = 32'h0000_0100;
        wrmem_addr = 32'h0000_0040;
        rdmem_req = 1'b1;
        wrmem_req = 1'b1;
        run_txn("rr1_rdmem", 3'b010, 48'hA000_0020_0000);
        run_txn("rr2_wrmem", 3'b100, 48'h2000_0008_0000);
        run_txn("rr3_rdmem", 3'b010, 48'hA000_0020_0000);

        // ---------------- all three requesting ----------------
        do_reset();
        rdreg_req = 1'b1;
        rdmem_req = 1'b1;
        wrmem_req = 1'b1;
        run_txn("all1_rdreg", 3'b001, 48'hE000_0000_0001);
        rdreg_req = 1'b0;
        run_txn("all2_rdmem", 3'b010, 48'hA000_0020_0000);
        run_txn("all3_wrmem", 3'b100, 48'h2000_0008_0000);
        run_txn("all4_rdmem", 3'b010, 48'hA000_0020_0000);

        // ---------------- pad mux and watchdog ----------------
        do_reset();
        rdmem_req  = 1'b1;
        sub_oe     = 3'b110;
        sub_oe_clk = 3'b010;
        sub_datain = {16'h1111, 16'hA5A5, 16'h2222};
        wr_rwds_oe = 1'b1;
        wr_rwds_out = 1'b1;
        wait_start(n);
        check_val("wd_start", {61'd0, sub_start}, 64'd2);
        @(posedge clk); #1;
        rdmem_req = 1'b0;
        @(negedge clk);
        n = 1;
        check_val("mux_oe", {63'd0, pad_oe}, 64'd1);
        check_val("mux_oe_clk", {63'd0, pad_oe_clk}, 64'd1);
        check_val("mux_data", {48'd0, pad_datain}, 64'h0000_0000_0000_A5A5);
        check_val("mux_rwds_oe", {63'd0, pad_rwds_oe}, 64'd0);
        while (!sub_rst && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("wd_latency", 64'(n), 64'd64);
        @(negedge clk);
        check_val("subrst_pulse", {63'd0, sub_rst}, 64'd0);
        check_val("terr_set", {63'd0, timeout_err}, 64'd1);
        repeat (5) @(negedge clk);
        check_val("terr_sticky", {63'd0, timeout_err}, 64'd1);
        check_val("post_abort_idle", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check_val("terr_clr", {63'd0, timeout_err}, 64'd0);

        // ---------------- reset during a write ----------------
        do_reset();
        wrmem_addr = 32'h0000_0040;
        wrmem_req  = 1'b1;
        wait_start(n);
        check_val("wr_start", {61'd0, sub_start}, 64'd4);
        @(posedge clk); #1;
        wrmem_req   = 1'b0;
        sub_csn     = 3'b011;
        wr_rwds_oe  = 1'b1;
        wr_rwds_out = 1'b1;
        sub_datain  = {16'h1234, 16'h0000, 16'h0000};
        @(negedge clk);
        check_val("wr_pad_csn", {63'd0, pad_csn}, 64'd0);
        check_val("wr_rwds_oe", {63'd0, pad_rwds_oe}, 64'd1);
        check_val("wr_rwds_out", {63'd0, pad_rwds_out}, 64'd1);
        check_val("wr_data", {48'd0, pad_datain}, 64'h1234);
        #1;
        rst = 1'b0;
        #1;
        check_val("arst_csn", {63'd0, pad_csn}, 64'd1);
        check_val("arst_rwds_oe", {63'd0, pad_rwds_oe}, 64'd0);
        check_val("arst_busy", {63'd0, busy}, 64'd0);
        check_val("arst_casig", {16'd0, casig}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_val("arst_stay_idle", {63'd0, busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
